// File: rtl/cfar_pkg.sv
// Shared types and default widths for the CFAR target collector.
//   tgt_rec_t    : target record layout (start index, peak index, peak power, width)
//   coll_state_e : run-merging FSM states
package cfar_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_IDX_W      = 10;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_CNT_W      = 8;

    // Field order matches the flat record word stored in the FIFO, MSB first.
    typedef struct packed {
        logic [DEF_IDX_W-1:0]  start_idx;
        logic [DEF_IDX_W-1:0]  peak_idx;
        logic [DEF_DATA_W-1:0] peak_power;
        logic [DEF_IDX_W-1:0]  width;
    } tgt_rec_t;

    typedef enum logic [0:0] {
        StIdle,
        StInTgt
    } coll_state_e;

endpackage

// File: rtl/cfar_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head.
//   clk, rst_n  : clock, async active-low reset
//   push, wdata : write request and data; accepted when not full or when popping
//   pop         : removes the head entry when not empty
//   rdata       : head entry (valid while !empty)
//   full, empty : occupancy flags
module cfar_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/cfar_target_collector.sv
// Merges runs of adjacent CFAR detections into target records and queues them
// for a downstream valid/ready consumer.
//   det_*           : per-cell detection stream (never back-pressured)
//   tgt_*           : record at FIFO head, popped on tgt_valid && tgt_ready
//   frame_done      : pulse one cycle after the eof beat, with frame_tgt_cnt
//   drop_cnt        : saturating count of records lost to a full FIFO
//   abort_err       : pulse one cycle after a sof that cut an open target/frame
module cfar_target_collector
    import cfar_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned IDX_W      = DEF_IDX_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              det_valid,
    input  logic              det_sof,
    input  logic              det_eof,
    input  logic              det_flag,
    input  logic [DATA_W-1:0] det_power,
    output logic              tgt_valid,
    input  logic              tgt_ready,
    output logic [IDX_W-1:0]  tgt_start_idx,
    output logic [IDX_W-1:0]  tgt_peak_idx,
    output logic [DATA_W-1:0] tgt_peak_power,
    output logic [IDX_W-1:0]  tgt_width,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_tgt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              abort_err
);

    localparam int unsigned REC_W = 3 * IDX_W + DATA_W;

    coll_state_e       state_q, state_d, eff_state;
    logic [IDX_W-1:0]  idx_q, idx_d, beat_idx;
    logic [IDX_W-1:0]  start_q, start_d, pk_idx_q, pk_idx_d, width_q, width_d;
    logic [DATA_W-1:0] pk_q, pk_d;
    logic              open_q, open_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, drop_q;
    logic              close;
    logic [REC_W-1:0]  close_rec, pend_rec_q, head;
    logic              pend_valid_q, done_q, abort_q;
    logic              full, empty, pop;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_d   = start_q;
        pk_idx_d  = pk_idx_q;
        pk_d      = pk_q;
        width_d   = width_q;
        open_d    = open_q;
        cnt_d     = cnt_q;
        close     = 1'b0;
        close_rec = {start_q, pk_idx_q, pk_q, width_q};
        beat_idx  = det_sof ? '0 : idx_q;
        // A sof discards any open target: the beat is handled as if from idle.
        eff_state = det_sof ? StIdle : state_q;

        if (det_valid) begin
            idx_d = beat_idx + 1'b1;
            unique case (eff_state)
                StIdle: begin
                    if (det_flag) begin
                        start_d  = beat_idx;
                        pk_idx_d = beat_idx;
                        pk_d     = det_power;
                        width_d  = IDX_W'(1);
                        if (det_eof) begin
                            close     = 1'b1;
                            close_rec = {beat_idx, beat_idx, det_power, IDX_W'(1)};
                            state_d   = StIdle;
                        end else begin
                            state_d = StInTgt;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StInTgt: begin
                    if (det_flag) begin
                        if (width_q != '1) width_d = width_q + 1'b1;
                        // Strict compare keeps the earliest of equal maxima.
                        if (det_power > pk_q) begin
                            pk_d     = det_power;
                            pk_idx_d = beat_idx;
                        end
                        if (det_eof) begin
                            close     = 1'b1;
                            close_rec = {start_d, pk_idx_d, pk_d, width_d};
                            state_d   = StIdle;
                        end
                    end else begin
                        close   = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (det_sof)      open_d = !det_eof;
            else if (det_eof) open_d = 1'b0;

            if (det_sof)                     cnt_d = close ? CNT_W'(1) : '0;
            else if (close && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            start_q      <= '0;
            pk_idx_q     <= '0;
            pk_q         <= '0;
            width_q      <= '0;
            open_q       <= 1'b0;
            cnt_q        <= '0;
            drop_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_rec_q   <= '0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            pk_idx_q     <= pk_idx_d;
            pk_q         <= pk_d;
            width_q      <= width_d;
            open_q       <= open_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= close;
            if (close) pend_rec_q <= close_rec;
            done_q       <= det_valid && det_eof;
            abort_q      <= det_valid && det_sof && (state_q == StInTgt || open_q);
            if (pend_valid_q && full && !pop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign pop = tgt_valid && tgt_ready;

    cfar_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pend_valid_q),
        .wdata (pend_rec_q),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign tgt_valid = !empty;
    // Head storage is not reset; hide it while the FIFO is empty.
    assign {tgt_start_idx, tgt_peak_idx, tgt_peak_power, tgt_width} = empty ? '0 : head;
    assign frame_done    = done_q;
    assign frame_tgt_cnt = cnt_q;
    assign drop_cnt      = drop_q;
    assign abort_err     = abort_q;

endmodule
